// File: rtl/drawing_canvas.sv
// drawing_canvas: 96x64 RGB565 framebuffer with push-button cursor, brush and full-canvas clear.
// Define CANVAS_CURSOR_BLINK_EN to blink the cursor overlay every BLINK_CYCLES.
module drawing_canvas #(
    parameter int          HOLD_CYCLES   = 25_000_000,
    parameter int          REPEAT_CYCLES = 5_000_000,
    parameter int          BLINK_CYCLES  = 50_000_000,
    parameter logic [15:0] CLEAR_COLOUR  = 16'hFFFF
) (
    input  logic        CLOCK,
    input  logic        reset_n,
    input  logic [12:0] pixel_index,
    input  logic [15:0] selected_colour,
    input  logic        sw13,
    input  logic        sw15,
    input  logic        btnU,
    input  logic        btnD,
    input  logic        btnL,
    input  logic        btnR,
    input  logic        btnC,
    output logic [15:0] curr_pixel_oled,
    output logic [6:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        busy
);
    localparam int NPIX = 6144;
    localparam int HMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(HMAX + 1);

    typedef enum logic {CLEAR, IDLE} state_t;
    state_t state, state_n;

    logic [15:0]   mem [NPIX];
    logic [15:0]   wr_data, rd_q;
    logic [12:0]   clr_addr, clr_addr_n, wr_addr, cur_addr, pix_q, cur_q;
    logic [3:0]    dir_q, dir_d, step, rep;
    logic [CW-1:0] hold_cnt [4];
    logic          btnC_q, sw15_q, sw15_d;
    logic          wr_en, active, clear_start, visible, up, dn, lf, rt;

    assign cur_addr    = 13'(cursor_y) * 13'd96 + 13'(cursor_x);
    assign active      = state == IDLE && !sw13;
    assign clear_start = state == IDLE && sw15_q && !sw15_d;
    assign busy        = state == CLEAR;

    always_ff @(posedge CLOCK) begin
        if (!reset_n) begin
            dir_q  <= '0;
            dir_d  <= '0;
            btnC_q <= 1'b0;
            sw15_q <= 1'b0;
            sw15_d <= 1'b0;
        end else begin
            dir_q  <= {btnR, btnL, btnD, btnU};
            dir_d  <= dir_q;
            btnC_q <= btnC;
            sw15_q <= sw15;
            sw15_d <= sw15_q;
        end
    end

    // A press steps once immediately, again after HOLD_CYCLES, then every REPEAT_CYCLES.
    always_comb begin
        step = '0;
        for (int i = 0; i < 4; i++)
            step[i] = active && dir_q[i] && (!dir_d[i] ||
                      hold_cnt[i] == (rep[i] ? CW'(REPEAT_CYCLES - 1) : CW'(HOLD_CYCLES - 1)));
    end

    always_ff @(posedge CLOCK) begin
        for (int i = 0; i < 4; i++) begin
            if (!reset_n || !active || !dir_q[i]) begin
                hold_cnt[i] <= '0;
                rep[i]      <= 1'b0;
            end else if (step[i]) begin
                hold_cnt[i] <= '0;
                rep[i]      <= dir_d[i];
            end else begin
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
        end
    end

    // Opposing buttons on one axis cancel each other.
    assign up = step[0] && !dir_q[1];
    assign dn = step[1] && !dir_q[0];
    assign lf = step[2] && !dir_q[3];
    assign rt = step[3] && !dir_q[2];

    always_ff @(posedge CLOCK) begin
        if (!reset_n) begin
            cursor_x <= 7'd48;
            cursor_y <= 6'd32;
        end else begin
            if (lf && cursor_x != 7'd0)
                cursor_x <= cursor_x - 1'b1;
            else if (rt && cursor_x != 7'd95)
                cursor_x <= cursor_x + 1'b1;
            if (up && cursor_y != 6'd0)
                cursor_y <= cursor_y - 1'b1;
            else if (dn && cursor_y != 6'd63)
                cursor_y <= cursor_y + 1'b1;
        end
    end

    always_ff @(posedge CLOCK) begin
        state    <= !reset_n ? CLEAR : state_n;
        clr_addr <= !reset_n ? '0 : clr_addr_n;
    end

    // The edge that starts a clear already writes address 0.
    always_comb begin
        state_n    = state;
        clr_addr_n = clr_addr;
        wr_en      = 1'b0;
        wr_addr    = cur_addr;
        wr_data    = selected_colour;
        if (state == CLEAR) begin
            wr_en      = 1'b1;
            wr_addr    = clr_addr;
            wr_data    = CLEAR_COLOUR;
            clr_addr_n = clr_addr + 1'b1;
            if (clr_addr == 13'(NPIX - 1))
                state_n = IDLE;
        end else if (clear_start) begin
            wr_en      = 1'b1;
            wr_addr    = '0;
            wr_data    = CLEAR_COLOUR;
            clr_addr_n = 13'd1;
            state_n    = CLEAR;
        end else begin
            wr_en = active && btnC_q;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_q <= mem[pixel_index];
    end

    // pix_q resets out of range so the output reads 0 before any memory read.
    always_ff @(posedge CLOCK) begin
        if (!reset_n) begin
            pix_q <= '1;
            cur_q <= '0;
        end else begin
            pix_q <= pixel_index;
            cur_q <= cur_addr;
        end
    end

    assign curr_pixel_oled = pix_q >= 13'(NPIX) ? 16'h0000 :
                             (pix_q == cur_q && visible) ? ~rd_q : rd_q;

`ifdef CANVAS_CURSOR_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    logic [BW-1:0] blink_cnt;

    always_ff @(posedge CLOCK) begin
        if (!reset_n || |step) begin
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            visible   <= !visible;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = |BLINK_CYCLES;
    assign visible      = 1'b1;
`endif
endmodule

// File: tb/tb_drawing_canvas.sv
// tb_drawing_canvas: directed checks of clear, movement, painting and read path of drawing_canvas.
module tb_drawing_canvas;
    logic        CLOCK = 1'b0;
    logic        reset_n = 1'b0;
    logic [12:0] pixel_index = '0;
    logic [15:0] selected_colour = '0;
    logic        sw13 = 1'b0, sw15 = 1'b0, btnC = 1'b0;
    logic [3:0]  btn = '0;
    logic [15:0] curr_pixel_oled;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        busy;
    int          checks = 0, errors = 0;

    drawing_canvas #(
        .HOLD_CYCLES(20), .REPEAT_CYCLES(5), .BLINK_CYCLES(8), .CLEAR_COLOUR(16'hFFFF)
    ) dut (
        .CLOCK(CLOCK), .reset_n(reset_n), .pixel_index(pixel_index),
        .selected_colour(selected_colour), .sw13(sw13), .sw15(sw15),
        .btnU(btn[0]), .btnD(btn[1]), .btnL(btn[2]), .btnR(btn[3]), .btnC(btnC),
        .curr_pixel_oled(curr_pixel_oled), .cursor_x(cursor_x), .cursor_y(cursor_y), .busy(busy)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tap(input int b);
        btn[b] = 1'b1;
        tick();
        btn[b] = 1'b0;
        tick();
    endtask

    initial begin
        int n, hi, bad, inv, raw;
        logic ok;
        repeat (3) tick();
        check("rst_busy", busy, 1);
        check("rst_x", cursor_x, 48);
        check("rst_y", cursor_y, 32);
        check("rst_pix", curr_pixel_oled, 16'h0000);

        reset_n = 1'b1;
        repeat (100) tick();
        btn[3] = 1'b1;
        repeat (10) tick();
        btn[3] = 1'b0;
        tick();
        check("move_in_clear", cursor_x, 48);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n = 0;
        while (busy && n < 7000) begin
            tick();
            n++;
        end
        check("clear_len", n, 6144);
        check("mid_rst_x", cursor_x, 48);

        pixel_index = 13'd0;    tick(); check("rd_0", curr_pixel_oled, 16'hFFFF);
        pixel_index = 13'd6143; tick(); check("rd_6143", curr_pixel_oled, 16'hFFFF);
        pixel_index = 13'd6200; tick(); check("rd_oob", curr_pixel_oled, 16'h0000);

        btn[3] = 1'b1;
        tick();
        btn[3] = 1'b0;
        check("tap_pre", cursor_x, 48);
        tick();
        check("tap_step", cursor_x, 49);
        repeat (30) tick();
        check("tap_once", cursor_x, 49);
        sw13 = 1'b1;
        tap(3);
        repeat (5) tick();
        check("sw13_block", cursor_x, 49);
        sw13 = 1'b0;

        repeat (47) tap(2);
        check("taps_left", cursor_x, 2);
        btn[2] = 1'b1;
        tick();
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 1)  check("holdL_e1", cursor_x, 1);
            if (e == 20) check("holdL_e20", cursor_x, 1);
            if (e == 21) check("holdL_e21", cursor_x, 0);
            if (e == 40) check("holdL_sat", cursor_x, 0);
        end
        btn[2] = 1'b0;
        btn[3] = 1'b1;
        tick();
        for (int e = 1; e <= 31; e++) begin
            tick();
            if (e == 1)  check("holdR_e1", cursor_x, 1);
            if (e == 21) check("holdR_e21", cursor_x, 2);
            if (e == 25) check("holdR_e25", cursor_x, 2);
            if (e == 26) check("holdR_e26", cursor_x, 3);
            if (e == 31) check("holdR_e31", cursor_x, 4);
        end
        btn[3] = 1'b0;
        tick();
        repeat (45) tap(3);
        check("taps_right", cursor_x, 49);
        btn[0] = 1'b1;
        btn[1] = 1'b1;
        repeat (30) tick();
        check("ud_cancel", cursor_y, 32);
        btn[0] = 1'b0;
        btn[1] = 1'b0;
        repeat (2) tick();
        repeat (40) tap(0);
        check("up_sat", cursor_y, 0);
        repeat (32) tap(1);
        check("down_back", cursor_y, 32);

        pixel_index = 13'd3121;
        selected_colour = 16'hF800;
        btnC = 1'b1;
        tick();
        btnC = 1'b0;
        tick();
        check("paint_rdfirst", curr_pixel_oled, 16'h0000);
        tick();
        check("paint_overlay", curr_pixel_oled, 16'h07FF);
        tap(3);
        tick();
        check("paint_raw", curr_pixel_oled, 16'hF800);
        pixel_index = 13'd3122;
        tick();
        check("cursor_overlay", curr_pixel_oled, 16'h0000);

        selected_colour = 16'h001F;
        btnC = 1'b1;
        repeat (3) tick();
        sw15 = 1'b1;
        tick();
        tick();
        check("clr_start", busy, 1);
        hi = 1;
        while (busy && hi < 8000) begin
            if (hi == 1000) sw15 = 1'b0;
            if (hi == 1010) sw15 = 1'b1;
            if (hi == 2000) btnC = 1'b0;
            tick();
            if (busy) hi++;
        end
        ok = hi >= 6143 && hi <= 6144;
        check("clr_len_fixed", ok, 1);
        sw15 = 1'b0;
        btnC = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 6144; i++) begin
            pixel_index = 13'(i);
            tick();
            if (i != 3122 && curr_pixel_oled !== 16'hFFFF) bad++;
        end
        check("clear_words", bad, 0);

        pixel_index = 13'd3122;
        tick();
        inv = 0;
        raw = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (curr_pixel_oled === 16'h0000) inv++;
            if (curr_pixel_oled === 16'hFFFF) raw++;
        end
        check("overlay_total", inv + raw, 16);
`ifdef CANVAS_CURSOR_BLINK_EN
        check("blink_inv", inv, 8);
`else
        check("steady_inv", inv, 16);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/drawing_canvas.md
# drawing_canvas

Framebuffer and brush engine for the drawing board. Stores a 96x64 RGB565 canvas, moves a cursor with the push buttons, and paints the colour chosen in the palette menu (its `selected_colour`) at the cursor. It serves the OLED pixel scan by returning `curr_pixel_oled`, which the palette overlay passes through wherever the menu is not drawn. It also runs a full-canvas clear sequence.

## Interface
- `HOLD_CYCLES`, 25_000_000: cycles a direction button must stay held after its first step before auto-repeat starts.
- `REPEAT_CYCLES`, 5_000_000: cycles between auto-repeat steps.
- `BLINK_CYCLES`, 50_000_000: cursor blink half-period. Used only with the blink macro.
- `CLEAR_COLOUR`, 16'hFFFF: colour written by a clear.
- `CLOCK` in 1: system clock. All logic is on the rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `pixel_index` in 13: OLED scan address, equal to y*96+x.
- `selected_colour` in 16: current brush colour (RGB565).
- `sw13` in 1: palette mode. While high, direction buttons and `btnC` are ignored.
- `sw15` in 1: clear request. Acts on its rising edge.
- `btnU` / `btnD` / `btnL` / `btnR` / `btnC` in 1 each: move up / down / left / right; paint.
- `curr_pixel_oled` out 16: canvas pixel at `pixel_index`, with the cursor overlay applied.
- `cursor_x` out 7 / `cursor_y` out 6: cursor position.
- `busy` out 1: high while a clear is in progress.

## Operation
- Memory: 6144 x 16. Address = y*96 + x, computed from the cursor for writes and taken directly from `pixel_index` for reads.
- Input sampling: all buttons and `sw15` are registered once into `*_q`. Edge detection and hold timing use the registered values only.
- FSM states: CLEAR and IDLE.
  - Reset enters CLEAR with the address counter at 0.
  - CLEAR writes `CLEAR_COLOUR` to one address per cycle, 0 through 6143, then enters IDLE.
  - IDLE goes to CLEAR when a rising edge is seen on `sw15_q`, with the address counter set to 0.
  - A `sw15` edge while already in CLEAR is ignored. The sequence does not restart.
- Movement (IDLE and `sw13` low only):
  - Each axis has its own step logic.
  - A rising edge on a direction button produces one step.
  - If the button stays held, one step follows after `HOLD_CYCLES`, then one every `REPEAT_CYCLES`.
  - Releasing the button resets its hold counter.
- Axis rules:
  - U and D held together: no y movement. L and R held together: no x movement.
  - One button per axis at once (diagonal) is allowed.
  - The cursor saturates at x 0..95 and y 0..63. It never wraps.
- Painting (IDLE and `sw13` low only):
  - While `btnC_q` is high, every cycle writes `selected_colour` at the cursor address.
  - The address used is the cursor value before that edge's step.
- Write priority: clear beats paint. In CLEAR, painting and movement are inhibited and hold counters are held at 0.
- Read path: `pixel_index` is registered together with the memory read (read-first), so `curr_pixel_oled` corresponds to the `pixel_index` of the previous edge.
  - If the registered index is at or above 6144, the output is 16'h0000.
  - If the registered index equals the registered cursor address and the cursor is visible, the output is the bitwise inverse (~) of the stored pixel.
- Reset values: `cursor_x`=48, `cursor_y`=32, `curr_pixel_oled`=0, `busy`=1. All counters are 0.

## Timing
- Read latency: 1 cycle. A read at edge k returns memory contents from before the write at edge k.
- Move latency: a button sampled high at edge k updates the cursor at edge k+1.
  - For a continuous hold, later steps land at k+1+`HOLD_CYCLES`, then every `REPEAT_CYCLES` after that.
- Paint latency: `btnC` sampled at edge k writes at edge k+1. The new colour is readable from edge k+2.
- Clear duration: exactly 6144 cycles of writes. `busy` falls on the edge that writes address 6143.
  - After a `sw15` rising edge is sampled at edge k, `busy` rises at edge k+1, and address 0 is written at that same edge.
- Reset mid-clear: CLEAR restarts from address 0 and the cursor returns to (48,32).

## Configuration
- `CANVAS_CURSOR_BLINK_EN` defined: cursor visibility toggles every `BLINK_CYCLES`. It is visible immediately after reset, and the blink counter resets on every cursor step so the cursor is visible right after a move.
- Macro undefined: the cursor is always visible and no blink counter is built.

## Test plan
Use `HOLD_CYCLES`=20, `REPEAT_CYCLES`=5, `BLINK_CYCLES`=8.
- Reset release: `busy`=1 for 6144 cycles, then 0. Reading index 0 and index 6143 both return 16'hFFFF. Index 6200 returns 16'h0000.
- Single tap: pulse `btnR` for 1 cycle. `cursor_x` goes 48→49 one edge after sampling, with no further change. With `sw13`=1 the same pulse gives no change.
- Hold `btnL` from x=2 for 40 cycles: x=1 at edge 1, x=0 at edge 21, then stays 0 (saturation). Holding U and D together leaves y=32.
- Paint: `selected_colour`=16'hF800, cursor at (49,32), 1-cycle `btnC` pulse. Index 3121 then reads 16'hF800 from the second edge after sampling; the cursor overlay gives 16'h07FF while visible.
- Clear racing paint: raise `sw15` while `btnC` is held. Painting stops and all 6144 words read 16'hFFFF. A second `sw15` edge mid-clear does not extend `busy` beyond 6144 cycles.
- With `CANVAS_CURSOR_BLINK_EN` defined: the cursor pixel alternates between inverted and stored value every 8 cycles. Without the macro it is always inverted.
